alu_mem_ctrl: RTL

- Bus-master sequencer for the ALU/memory slave's register port (addr, wr_data, rd_wr, enable, rd_data, res_out).
- Accepts one operation per command handshake: operand A, operand B and opcode.
- Writes them into the slave's registers, polls the slave status register until done or timeout, then returns the 16-bit result on a response handshake.
- Sits between testbench/CPU-side traffic and the ALU slave. It is the only master on the slave port.

---
 rtl/alu_mem_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/alu_mem_ctrl.sv
// rtl/alu_mem_ctrl.sv - bus-master sequencer driving the ALU/memory slave register port
// Writes A/B/opcode, polls status until done or timeout, returns the result on a response handshake.
module alu_mem_ctrl #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8,
    parameter int RES_WIDTH  = 16,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] cmd_a,
    input  logic [DATA_WIDTH-1:0] cmd_b,
    input  logic [DATA_WIDTH-1:0] cmd_op,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [RES_WIDTH-1:0]  rsp_data,
    output logic                  rsp_err,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_wr,
    output logic                  enable,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic [RES_WIDTH-1:0]  res_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_A,
        S_WR_B,
        S_WR_OP,
        S_RD_REQ,
        S_RD_WAIT,
        S_RESP
    } state_t;

    localparam logic [7:0] POLL_LIMIT = 8'(TIMEOUT);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] op_q, op_d;
    logic [7:0]            poll_q, poll_d;
    logic [RES_WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  busy_q, busy_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  rd_wr_q, rd_wr_d;
    logic                  enable_q, enable_d;

    // Only the done flag of the status register carries meaning.
    logic unused_rd_bits;
    assign unused_rd_bits = ^rd_data[DATA_WIDTH-1:1];

    always_comb begin
        state_d     = state_q;
        b_d         = b_q;
        op_d        = op_q;
        poll_d      = poll_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        rsp_valid_d = rsp_valid_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    b_d     = cmd_b;
                    op_d    = cmd_op;
                    state_d = S_WR_A;
                end
            end
            S_WR_A:  state_d = S_WR_B;
            S_WR_B:  state_d = S_WR_OP;
            S_WR_OP: begin
                poll_d  = 8'd0;
                state_d = S_RD_REQ;
            end
            S_RD_REQ: begin
                poll_d  = poll_q + 8'd1;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (rd_data[0]) begin
                    rsp_data_d  = res_out;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else if (poll_q == POLL_LIMIT) begin
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    state_d = S_RD_REQ;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus and status outputs are decoded from the next state so they are flop outputs
    // aligned with the state that owns them. A goes straight from cmd_a into wr_data.
    always_comb begin
        addr_d    = '0;
        wr_data_d = '0;
        rd_wr_d   = 1'b0;
        enable_d  = 1'b0;
        case (state_d)
            S_WR_A: begin
                enable_d  = 1'b1;
                addr_d    = ADDR_WIDTH'(0);
                wr_data_d = cmd_a;
            end
            S_WR_B: begin
                enable_d  = 1'b1;
                addr_d    = ADDR_WIDTH'(1);
                wr_data_d = b_q;
            end
            S_WR_OP: begin
                enable_d  = 1'b1;
                addr_d    = ADDR_WIDTH'(2);
                wr_data_d = op_q;
            end
            S_RD_REQ: begin
                enable_d = 1'b1;
                rd_wr_d  = 1'b1;
                addr_d   = ADDR_WIDTH'(3);
            end
            default: ;
        endcase
        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            b_q         <= '0;
            op_q        <= '0;
            poll_q      <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            addr_q      <= '0;
            wr_data_q   <= '0;
            rd_wr_q     <= 1'b0;
            enable_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            b_q         <= b_d;
            op_q        <= op_d;
            poll_q      <= poll_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= rsp_valid_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            addr_q      <= addr_d;
            wr_data_q   <= wr_data_d;
            rd_wr_q     <= rd_wr_d;
            enable_q    <= enable_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
    assign addr      = addr_q;
    assign wr_data   = wr_data_q;
    assign rd_wr     = rd_wr_q;
    assign enable    = enable_q;

endmodule
